// File: rtl/ysyx_23060061_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060061_mem_arbiter
// Brief    : Round-robin arbiter sharing one AXI-Lite slave between IFU and LSU.
// Revision : 1.0
// ============================================================================
module ysyx_23060061_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // IFU read-only master
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    // LSU read/write master
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    // Shared slave
    output logic [ADDR_W-1:0]   s_araddr,
    output logic                s_arvalid,
    input  logic                s_arready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rvalid,
    output logic                s_rready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wvalid,
    input  logic                s_wready,
    input  logic [1:0]          s_bresp,
    input  logic                s_bvalid,
    output logic                s_bready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_last;        // 0 = IFU, 1 = LSU
    logic   w_last_nxt;
    logic   r_aw_done;
    logic   r_w_done;

    logic   w_own_ifu;
    logic   w_own_lsu_rd;
    logic   w_own_lsu_wr;
    logic   w_wr_addr_data_done;
    logic   w_grant_lsu;
    logic   w_r_hs;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_b_hs;

    // Ownership is masked by rst so every valid/ready drops in the reset cycle itself.
    assign w_own_ifu           = !rst && (r_state == IFU_RD);
    assign w_own_lsu_rd        = !rst && (r_state == LSU_RD);
    assign w_own_lsu_wr        = !rst && (r_state == LSU_WR);
    assign w_wr_addr_data_done = r_aw_done && r_w_done;

    // LSU wins when alone, or on a tie when IFU was the last owner.
    assign w_grant_lsu = (lsu_arvalid || lsu_awvalid) && (!ifu_arvalid || !r_last);

    always_comb begin
        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        if (w_own_ifu) begin
            s_araddr    = ifu_araddr;
            s_arvalid   = ifu_arvalid;
            ifu_arready = s_arready;
            ifu_rdata   = s_rdata;
            ifu_rresp   = s_rresp;
            ifu_rvalid  = s_rvalid;
            s_rready    = ifu_rready;
        end else if (w_own_lsu_rd) begin
            s_araddr    = lsu_araddr;
            s_arvalid   = lsu_arvalid;
            lsu_arready = s_arready;
            lsu_rdata   = s_rdata;
            lsu_rresp   = s_rresp;
            lsu_rvalid  = s_rvalid;
            s_rready    = lsu_rready;
        end
    end

    // Write channels: AW and W each retire independently; B waits for both.
    always_comb begin
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        if (w_own_lsu_wr) begin
            s_awaddr    = lsu_awaddr;
            s_awvalid   = lsu_awvalid && !r_aw_done;
            lsu_awready = s_awready && !r_aw_done;
            s_wdata     = lsu_wdata;
            s_wstrb     = lsu_wstrb;
            s_wvalid    = lsu_wvalid && !r_w_done;
            lsu_wready  = s_wready && !r_w_done;
            s_bready    = lsu_bready && w_wr_addr_data_done;
            lsu_bvalid  = s_bvalid && w_wr_addr_data_done;
            lsu_bresp   = s_bresp;
        end
    end

    assign w_r_hs  = s_rvalid && s_rready;
    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_b_hs  = s_bvalid && s_bready;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_grant_lsu) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = lsu_awvalid ? LSU_WR : LSU_RD;
                end else if (ifu_arvalid) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = IFU_RD;
                end
            end
            IFU_RD, LSU_RD: begin
                if (w_r_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            LSU_WR: begin
                if (w_b_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
